// File: rtl/bitcnt_issue_pkg.sv
// -----------------------------------------------------------------------------
// bitcnt_issue_pkg
// Purpose : shared encodings for the Zbb count issue stage: opcode / funct
//           constants, the bitcnt function enum and the instruction decoder.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package bitcnt_issue_pkg;

  localparam logic [6:0] OPC_OPIMM   = 7'h13;
  localparam logic [6:0] OPC_OPIMM32 = 7'h1B;
  localparam logic [6:0] FUNCT7_CNT  = 7'b0110000;
  localparam logic [2:0] FUNCT3_CNT  = 3'b001;

  // Encoding is {insn[21:20], is_w}, so the decoder can build it directly.
  typedef enum logic [2:0] {
    FN_CLZ64  = 3'b000,
    FN_CLZ32  = 3'b001,
    FN_CTZ64  = 3'b010,
    FN_CTZ32  = 3'b011,
    FN_PCNT64 = 3'b100,
    FN_PCNT32 = 3'b101
  } func_e;

  typedef struct packed {
    logic  legal;
    func_e func;
  } dec_t;

  function automatic dec_t decode_insn(input logic [31:0] insn);
    dec_t d;
    logic is_w;
    logic opc_ok;
    opc_ok  = (insn[6:0] == OPC_OPIMM) || (insn[6:0] == OPC_OPIMM32);
    is_w    = (insn[6:0] == OPC_OPIMM32);
    d.legal = (insn[31:25] == FUNCT7_CNT) &&
              (insn[24:22] == 3'b000) &&
              (insn[21:20] != 2'b11) &&
              (insn[14:12] == FUNCT3_CNT) &&
              opc_ok;
    // Illegal ops still travel down the pipe; give them a harmless func.
    if (d.legal) begin
      d.func = func_e'({insn[21:20], is_w});
    end else begin
      d.func = FN_CLZ64;
    end
    return d;
  endfunction

endpackage

// File: rtl/bitcnt_issue_bitcnt.sv
// -----------------------------------------------------------------------------
// bitcnt
// Purpose : combinational count unit: clz / ctz / cpop in 64-bit and W forms.
// Ports   : din_data  [63:0] operand
//           din_func  [2:0]  function select (bitcnt_issue_pkg::func_e)
//           dout_data [63:0] zero-extended count
// -----------------------------------------------------------------------------
module bitcnt
  import bitcnt_issue_pkg::*;
(
  input  logic [63:0] din_data,
  input  logic [2:0]  din_func,
  output logic [63:0] dout_data
);

  function automatic logic [6:0] lzc64(input logic [63:0] x);
    logic [6:0] n;
    n = 7'd64;
    // Highest set bit is visited last and wins.
    for (int i = 0; i < 64; i++) begin
      if (x[i]) begin
        n = 7'd63 - 7'(i);
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] tzc64(input logic [63:0] x);
    logic [6:0] n;
    n = 7'd64;
    // Lowest set bit is visited last and wins.
    for (int i = 63; i >= 0; i--) begin
      if (x[i]) begin
        n = 7'(i);
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] pop64(input logic [63:0] x);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, x[i]};
    end
    return n;
  endfunction

  logic [6:0] cnt;

  // W forms reuse the 64-bit counters: a sentinel bit just past the low word
  // caps clz32/ctz32 at 32 and the upper half is never looked at.
  always_comb begin
    cnt = 7'd0;
    case (din_func)
      FN_CLZ64:  cnt = lzc64(din_data);
      FN_CLZ32:  cnt = lzc64({din_data[31:0], 1'b1, 31'd0});
      FN_CTZ64:  cnt = tzc64(din_data);
      FN_CTZ32:  cnt = tzc64({31'd0, 1'b1, din_data[31:0]});
      FN_PCNT64: cnt = pop64(din_data);
      FN_PCNT32: cnt = pop64({32'd0, din_data[31:0]});
      default:   cnt = 7'd0;
    endcase
  end

  assign dout_data = {57'd0, cnt};

endmodule

// File: rtl/bitcnt_issue.sv
// -----------------------------------------------------------------------------
// bitcnt_issue
// Purpose : issue/decode stage for the bitcnt unit. Two registered stages:
//           S1 holds the decoded op, S2 holds the count result. Full
//           throughput, backpressure safe, synchronous flush.
// Ports   : clock, reset (sync, active-high), flush (sync kill)
//           in_valid/in_ready, in_insn[31:0], in_rs1[63:0], in_tag[TAG_W-1:0]
//           out_valid/out_ready, out_data[63:0], out_rd[4:0],
//           out_tag[TAG_W-1:0], out_illegal
// -----------------------------------------------------------------------------
module bitcnt_issue #(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [63:0]      in_rs1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [4:0]       out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  import bitcnt_issue_pkg::*;

  logic             s1_valid_q,   s1_valid_d;
  func_e            s1_func_q,    s1_func_d;
  logic             s1_illegal_q, s1_illegal_d;
  logic [63:0]      s1_rs1_q,     s1_rs1_d;
  logic [4:0]       s1_rd_q,      s1_rd_d;
  logic [TAG_W-1:0] s1_tag_q,     s1_tag_d;

  logic             s2_valid_q,   s2_valid_d;
  logic [63:0]      s2_data_q,    s2_data_d;
  logic [4:0]       s2_rd_q,      s2_rd_d;
  logic [TAG_W-1:0] s2_tag_q,     s2_tag_d;
  logic             s2_illegal_q, s2_illegal_d;

  logic        s1_en;
  logic        s2_en;
  dec_t        dec;
  logic [63:0] bc_data;

  // A stage may load when it is empty or its content moves on this cycle.
  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en && !flush;
  assign dec      = decode_insn(in_insn);

  bitcnt u_bitcnt (
    .din_data  (s1_rs1_q),
    .din_func  (s1_func_q),
    .dout_data (bc_data)
  );

  // S1 next state: capture the decoded op on accept, drop everything on flush.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_func_d    = s1_func_q;
    s1_illegal_d = s1_illegal_q;
    s1_rs1_d     = s1_rs1_q;
    s1_rd_d      = s1_rd_q;
    s1_tag_d     = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_func_d    = dec.func;
        s1_illegal_d = !dec.legal;
        s1_rs1_d     = in_rs1;
        s1_rd_d      = in_insn[11:7];
        s1_tag_d     = in_tag;
      end else begin
        s1_func_d = s1_func_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2 next state: register the count, forced to zero for illegal ops.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_rd_d      = s2_rd_q;
    s2_tag_d     = s2_tag_q;
    s2_illegal_d = s2_illegal_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d    = s1_illegal_q ? 64'd0 : bc_data;
        s2_rd_d      = s1_rd_q;
        s2_tag_d     = s1_tag_q;
        s2_illegal_d = s1_illegal_q;
      end else begin
        s2_data_d = s2_data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_func_q    <= FN_CLZ64;
      s1_illegal_q <= 1'b0;
      s1_rs1_q     <= 64'd0;
      s1_rd_q      <= 5'd0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= 64'd0;
      s2_rd_q      <= 5'd0;
      s2_tag_q     <= '0;
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_func_q    <= s1_func_d;
      s1_illegal_q <= s1_illegal_d;
      s1_rs1_q     <= s1_rs1_d;
      s1_rd_q      <= s1_rd_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_rd_q      <= s2_rd_d;
      s2_tag_q     <= s2_tag_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_rd      = s2_rd_q;
  assign out_tag     = s2_tag_q;
  assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_bitcnt_issue.sv
// -----------------------------------------------------------------------------
// tb_bitcnt_issue
// Purpose : directed + randomized bench for bitcnt_issue with an in-order
//           scoreboard fed by an arithmetic reference of the count insns.
// -----------------------------------------------------------------------------
module tb_bitcnt_issue;

  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_insn;
  logic [63:0]      in_rs1, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [4:0]       out_rd;
  logic             out_illegal;

  bitcnt_issue #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .in_rs1(in_rs1), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0]      data;
    logic [4:0]       rd;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic stall_prev = 1'b0;
  exp_t prev_out;
  logic last_accept;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: count directly from the instruction semantics.
  function automatic exp_t model(input logic [31:0] insn, input logic [63:0] rs1,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    logic legal, w;
    int width, n;
    logic [63:0] v;
    legal = (insn[31:25] == 7'b0110000) && (insn[24:22] == 3'b000) &&
            (insn[21:20] != 2'b11) && (insn[14:12] == 3'b001) &&
            ((insn[6:0] == 7'h13) || (insn[6:0] == 7'h1B));
    w     = (insn[6:0] == 7'h1B);
    width = w ? 32 : 64;
    v     = w ? {32'd0, rs1[31:0]} : rs1;
    n     = 0;
    if (insn[21:20] == 2'b00) begin
      while (n < width && v[width-1-n] == 1'b0) n++;
    end else if (insn[21:20] == 2'b01) begin
      while (n < width && v[n] == 1'b0) n++;
    end else begin
      n = $countones(v);
    end
    e.data = legal ? 64'(n) : 64'd0;
    e.rd   = insn[11:7];
    e.tag  = tag;
    e.ill  = !legal;
    return e;
  endfunction

  function automatic logic [31:0] gen_insn();
    logic [31:0] x;
    if ($urandom_range(0, 9) == 0) return $urandom();
    x = {7'b0110000, 3'b000, 2'($urandom_range(0, 3)), 5'($urandom),
         3'b001, 5'($urandom), ($urandom_range(0, 1) == 1) ? 7'h1B : 7'h13};
    if ($urandom_range(0, 7) == 0) x[14:12] = 3'($urandom);
    if ($urandom_range(0, 7) == 0) x[22] = 1'b1;
    return x;
  endfunction

  function automatic logic [63:0] gen_rs1();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 4))
      0: r = 64'd0;
      1: r = r >> $urandom_range(0, 63);
      2: r = r << $urandom_range(0, 63);
      default: r = r;
    endcase
    return r;
  endfunction

  // Observe handshakes / stability at the negedge, then pass one posedge.
  task automatic sample();
    exp_t cur, e;
    cur = '{data: out_data, rd: out_rd, tag: out_tag, ill: out_illegal};
    last_accept = 1'b0;
    if (flush === 1'b1 && reset === 1'b0) chk(in_ready, 1'b0, "in_ready_flush");
    if (stall_prev) begin
      chk(out_valid, 1'b1, "stall_valid");
      chk(cur, prev_out, "stall_stable");
    end
    if (reset === 1'b0) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (expq.size() == 0) begin
          chk(out_valid, 1'b0, "unexpected_out");
        end else begin
          e = expq.pop_front();
          chk(out_data, e.data, "data");
          chk(out_rd, e.rd, "rd");
          chk(out_tag, e.tag, "tag");
          chk(out_illegal, e.ill, "illegal");
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        expq.push_back(model(in_insn, in_rs1, in_tag));
        last_accept = 1'b1;
      end
    end
    stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0) &&
                 (flush === 1'b0) && (reset === 1'b0);
    prev_out = cur;
  endtask

  task automatic cycle();
    @(negedge clock);
    sample();
    @(posedge clock);
    if (reset || flush) expq.delete();
    #1;
  endtask

  // Direct look at the outputs; callers hold in_valid=0 and out_ready=0.
  task automatic peek(input logic ev, input logic fields, input logic [63:0] ed,
                      input logic [4:0] erd, input logic [TAG_W-1:0] et,
                      input logic eill, input string tag);
    @(negedge clock);
    chk(out_valid, ev, {tag, "_valid"});
    if (fields) begin
      chk(out_data, ed, {tag, "_data"});
      chk(out_rd, erd, {tag, "_rd"});
      chk(out_tag, et, {tag, "_tag"});
      chk(out_illegal, eill, {tag, "_illegal"});
    end
    @(posedge clock);
    #1;
  endtask

  // Single op into an empty pipe: result must appear exactly two cycles later.
  task automatic run_one(input logic [31:0] insn, input logic [63:0] rs1,
                         input logic [TAG_W-1:0] tag, input logic [63:0] ed,
                         input logic eill, input string name);
    out_ready = 1'b0;
    in_valid = 1'b1; in_insn = insn; in_rs1 = rs1; in_tag = tag;
    cycle();
    chk(last_accept, 1'b1, {name, "_accept"});
    in_valid = 1'b0;
    peek(1'b0, 1'b0, 64'd0, 5'd0, '0, 1'b0, {name, "_n1"});
    peek(1'b1, 1'b1, ed, insn[11:7], tag, eill, {name, "_n2"});
    out_ready = 1'b1;
    cycle();
  endtask

  initial begin
    int sent;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_insn = 32'd0; in_rs1 = 64'd0; in_tag = '0;
    #1;
    cycle(); cycle();
    reset = 1'b0;
    peek(1'b0, 1'b1, 64'd0, 5'd0, '0, 1'b0, "reset");

    // Idle with out_ready high.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk(out_valid, 1'b0, "idle_valid");
      chk(in_ready, 1'b1, "idle_ready");
      @(posedge clock); #1;
    end

    run_one(32'h60001013, 64'h0000_0001_0000_0000, 4'd1, 64'd31, 1'b0, "clz");
    run_one(32'h6020101B, 64'hFFFF_FFFF_0000_00FF, 4'd2, 64'd8,  1'b0, "cpopw");
    run_one(32'h60101093, 64'd0,                   4'd3, 64'd64, 1'b0, "ctz0");
    run_one(32'h6010109B, 64'hFFFF_FFFF_0000_0000, 4'd4, 64'd32, 1'b0, "ctzw0");
    run_one(32'h6000111B, 64'h0000_0000_0001_0000, 4'd5, 64'd15, 1'b0, "clzw");
    run_one(32'h60301013, 64'h1234,                4'd6, 64'd0,  1'b1, "ill_rs2");
    run_one(32'h60005013, 64'h1234,                4'd7, 64'd0,  1'b1, "ill_f3");

    // Back-to-back 8 ops with out_ready 1,0,0,1,0,0,...
    sent = 0;
    for (int c = 0; c < 80 && (sent < 8 || expq.size() > 0); c++) begin
      in_valid = (sent < 8);
      if (in_valid) begin
        in_insn = {7'b0110000, 3'b000, 2'(sent % 3), 5'd1, 3'b001, 5'(sent + 8),
                   (sent[0] ? 7'h1B : 7'h13)};
        in_rs1  = gen_rs1();
        in_tag  = TAG_W'(sent);
      end
      out_ready = (c % 3 == 0);
      cycle();
      if (last_accept) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk(32'(sent), 32'd8, "b2b_sent");
    chk(32'(expq.size()), 32'd0, "b2b_drained");

    // Fill both stages, stall, then flush.
    out_ready = 1'b0;
    in_valid = 1'b1; in_insn = 32'h60001013; in_rs1 = 64'hFF; in_tag = 4'd8;
    cycle();
    in_tag = 4'd9;
    cycle();
    chk(last_accept, 1'b1, "fill_second_accept");
    in_tag = 4'd10; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    peek(1'b0, 1'b0, 64'd0, 5'd0, '0, 1'b0, "post_flush");
    run_one(32'h60201013, 64'hF0F0, 4'd11, 64'd8, 1'b0, "after_flush");

    // Reset mid-operation clears outputs.
    out_ready = 1'b0;
    in_valid = 1'b1; in_insn = 32'h60101F93; in_rs1 = 64'h80; in_tag = 4'd12;
    cycle(); cycle();
    in_valid = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    peek(1'b0, 1'b1, 64'd0, 5'd0, '0, 1'b0, "mid_reset");
    out_ready = 1'b1;

    // Randomized traffic with stalls and occasional flush.
    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || last_accept) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_insn  = gen_insn();
        in_rs1   = gen_rs1();
        in_tag   = TAG_W'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    chk(32'(expq.size()), 32'd0, "rand_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
